imm_decode_stage: RTL and testbench

Registered, parametrised immediate-decode stage for the OTTER pipeline front end. Accepts a 32-bit RV instruction and its PC through a valid/ready handshake, classifies the instruction format from the opcode, produces the sign-extended XLEN-wide immediate and the PC-relative target (`pc + imm`), and holds results in a two-entry skid buffer so backpressure never creates a combinational ready path. It sits between fetch and the register-read/execute stage.

---
 rtl/imm_gen_pkg.sv | 47 ++++
 rtl/imm_decode_comb.sv | 74 +++++++
 rtl/imm_decode_stage.sv | 122 ++++++++++++
 tb/tb_imm_decode_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imm_gen_pkg
// Purpose : Shared types and constants for the OTTER immediate-decode stage:
//           format codes, RV32/RV64 base opcodes and the buffered entry record.
// Ports   : none (package)
// Config  : IMMGEN_ZIMM_EN enables the FMT_Z (CSR zimm) decode in users.
// Revision: 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

  // Widest supported datapath; buffered entries are stored at this width and
  // narrower instances use only the low XLEN bits.
  localparam int c_XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } imm_fmt_t;

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [c_XLEN_MAX-1:0] imm;
    imm_fmt_t              fmt;
    logic [c_XLEN_MAX-1:0] target;
    logic [c_XLEN_MAX-1:0] pc;
    logic                  illegal;
  } decode_entry_t;

endpackage
`default_nettype wire

// File: rtl/imm_decode_comb.sv
`default_nettype none
// ============================================================================
// Module  : imm_decode_comb
// Purpose : Combinational opcode classification, sign-extended immediate and
//           PC-relative target generation.
// Ports   : i_inst   - 32-bit instruction word
//           i_pc     - instruction address (XLEN)
//           o_imm    - immediate, sign-extended to XLEN (zero for R/ILL)
//           o_fmt    - instruction format code
//           o_target - i_pc + o_imm modulo 2^XLEN
//           o_illegal- opcode not recognised
// Config  : IMMGEN_ZIMM_EN - CSR*I instructions decode as FMT_Z with the
//           5-bit zimm field zero-extended; otherwise they decode as FMT_I.
// Revision: 1.0 - initial release
// ============================================================================
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_t        o_fmt,
  output logic [XLEN-1:0] o_target,
  output logic            o_illegal
);

  imm_fmt_t w_fmt;

  always_comb begin
    w_fmt = FMT_ILL;
    case (i_inst[6:0])
      c_OPC_LUI, c_OPC_AUIPC:            w_fmt = FMT_U;
      c_OPC_JAL:                         w_fmt = FMT_J;
      c_OPC_JALR, c_OPC_LOAD, c_OPC_OPIMM: w_fmt = FMT_I;
      c_OPC_SYSTEM: begin
`ifdef IMMGEN_ZIMM_EN
        // funct3[2] set selects the immediate CSR forms.
        w_fmt = i_inst[14] ? FMT_Z : FMT_I;
`else
        w_fmt = FMT_I;
`endif
      end
      c_OPC_STORE:                       w_fmt = FMT_S;
      c_OPC_BRANCH:                      w_fmt = FMT_B;
      c_OPC_OP:                          w_fmt = FMT_R;
      default:                           w_fmt = FMT_ILL;
    endcase
  end

  // Sized casts of signed operands sign-extend to XLEN, which also covers the
  // U format on 64-bit datapaths.
  always_comb begin
    o_imm = '0;
    case (w_fmt)
      FMT_I: o_imm = XLEN'($signed(i_inst[31:20]));
      FMT_S: o_imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
      FMT_B: o_imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25],
                                    i_inst[11:8], 1'b0}));
      FMT_U: o_imm = XLEN'($signed({i_inst[31:12], 12'b0}));
      FMT_J: o_imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20],
                                    i_inst[30:21], 1'b0}));
      FMT_Z: o_imm = XLEN'(i_inst[19:15]);
      default: o_imm = '0;
    endcase
  end

  assign o_fmt     = w_fmt;
  assign o_target  = i_pc + o_imm;
  assign o_illegal = (w_fmt == FMT_ILL);

endmodule
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : imm_decode_stage
// Purpose : Registered immediate-decode stage with valid/ready handshake and
//           a two-entry (main + skid) buffer so in_ready is a pure register.
// Ports   : CLK, RST (async, active-high), flush (sync discard)
//           in_valid/in_ready/in_inst/in_pc       - upstream handshake
//           out_valid/out_ready                   - downstream handshake
//           out_imm/out_fmt/out_target/out_pc/out_illegal - decoded entry
// Params  : XLEN - datapath width, 32 or 64
// Config  : IMMGEN_ZIMM_EN - forwarded to imm_decode_comb (FMT_Z decode)
// Revision: 1.0 - initial release
// ============================================================================
module imm_decode_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  logic [XLEN-1:0] w_decImm;
  logic [XLEN-1:0] w_decTarget;
  imm_fmt_t        w_decFmt;
  logic            w_decIllegal;
  decode_entry_t   w_newEntry;

  decode_entry_t   r_main;
  decode_entry_t   r_skid;
  logic            r_mainValid;
  logic            r_skidValid;

  logic            w_inFire;
  logic            w_outFire;
  logic            w_mainFree;

  imm_decode_comb #(
    .XLEN(XLEN)
  ) u_decode (
    .i_inst   (in_inst),
    .i_pc     (in_pc),
    .o_imm    (w_decImm),
    .o_fmt    (w_decFmt),
    .o_target (w_decTarget),
    .o_illegal(w_decIllegal)
  );

  always_comb begin
    w_newEntry         = '0;
    w_newEntry.imm     = c_XLEN_MAX'(w_decImm);
    w_newEntry.fmt     = w_decFmt;
    w_newEntry.target  = c_XLEN_MAX'(w_decTarget);
    w_newEntry.pc      = c_XLEN_MAX'(in_pc);
    w_newEntry.illegal = w_decIllegal;
  end

  assign w_inFire   = in_valid && !r_skidValid;
  assign w_outFire  = r_mainValid && out_ready;
  // Main can take a new occupant on this edge if empty or being drained.
  assign w_mainFree = !r_mainValid || w_outFire;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_main      <= '0;
      r_skid      <= '0;
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (flush) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (w_mainFree) begin
      // Skid is always older than the incoming entry, so it moves first.
      // A full skid also means in_ready was low, so no input fires here.
      if (r_skidValid) begin
        r_main      <= r_skid;
        r_mainValid <= 1'b1;
        r_skidValid <= 1'b0;
      end else if (w_inFire) begin
        r_main      <= w_newEntry;
        r_mainValid <= 1'b1;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_inFire) begin
      r_skid      <= w_newEntry;
      r_skidValid <= 1'b1;
    end
  end

  assign in_ready    = !r_skidValid;
  assign out_valid   = r_mainValid;
  assign out_imm     = r_main.imm[XLEN-1:0];
  assign out_fmt     = r_main.fmt;
  assign out_target  = r_main.target[XLEN-1:0];
  assign out_pc      = r_main.pc[XLEN-1:0];
  assign out_illegal = r_main.illegal;

  // Narrow instances never read the upper halves of the stored entry.
  generate
    if (XLEN < c_XLEN_MAX) begin : g_unusedHi
      logic w_unusedHi;
      assign w_unusedHi = ^{r_main.imm[c_XLEN_MAX-1:XLEN],
                            r_main.target[c_XLEN_MAX-1:XLEN],
                            r_main.pc[c_XLEN_MAX-1:XLEN]};
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_imm_decode_stage
// Purpose : Self-checking bench for imm_decode_stage; XLEN=32 and XLEN=64
//           instances share one input stream and one FIFO reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] target;
    logic [63:0] pc;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] target;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic [31:0] inInst = '0;
  logic [63:0] inPc = '0;
  logic        outReady = 1'b0;

  logic        inReady32, outValid32, outIll32;
  logic [31:0] outImm32, outTarget32, outPc32;
  logic [2:0]  outFmt32;
  logic        inReady64, outValid64, outIll64;
  logic [63:0] outImm64, outTarget64, outPc64;
  logic [2:0]  outFmt64;

  int nChecks = 0;
  int nErrors = 0;
  exp_t q[$];

  always #5 CLK = ~CLK;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(inValid), .in_ready(inReady32), .in_inst(inInst), .in_pc(inPc[31:0]),
    .out_valid(outValid32), .out_ready(outReady), .out_imm(outImm32), .out_fmt(outFmt32),
    .out_target(outTarget32), .out_pc(outPc32), .out_illegal(outIll32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(inValid), .in_ready(inReady64), .in_inst(inInst), .in_pc(inPc),
    .out_valid(outValid64), .out_ready(outReady), .out_imm(outImm64), .out_fmt(outFmt64),
    .out_target(outTarget64), .out_pc(outPc64), .out_illegal(outIll64)
  );

  // Reference decode from the format rules, using signed arithmetic on the
  // whole instruction word rather than bit concatenation.
  function automatic exp_t refDecode(input logic [31:0] inst, input logic [63:0] pc);
    exp_t   e;
    longint s, u, hi;
    s = $signed(inst);
    u = longint'({32'b0, inst});
    e.fmt = 3'd7;
    e.imm = '0;
    case (inst[6:0])
      7'h37, 7'h17:        e.fmt = 3'd4;
      7'h6F:               e.fmt = 3'd5;
      7'h67, 7'h03, 7'h13: e.fmt = 3'd1;
      7'h23:               e.fmt = 3'd2;
      7'h63:               e.fmt = 3'd3;
      7'h33:               e.fmt = 3'd0;
      7'h73: begin
`ifdef IMMGEN_ZIMM_EN
        e.fmt = (((u >> 12) % 8) >= 4) ? 3'd6 : 3'd1;
`else
        e.fmt = 3'd1;
`endif
      end
      default:             e.fmt = 3'd7;
    endcase
    case (e.fmt)
      3'd1: begin hi = s >>> 20; e.imm = hi; end
      3'd2: begin hi = s >>> 25; e.imm = hi * 32 + (u >> 7) % 32; end
      3'd3: begin
        hi = s >>> 31;
        e.imm = hi * 4096 + ((u >> 7) % 2) * 2048 + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2;
      end
      3'd4: begin hi = s >>> 12; e.imm = hi * 4096; end
      3'd5: begin
        hi = s >>> 31;
        e.imm = hi * 1048576 + ((u >> 12) % 256) * 4096 + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2;
      end
      3'd6: e.imm = (u >> 15) % 32;
      default: e.imm = '0;
    endcase
    e.target = pc + e.imm;
    e.pc     = pc;
    e.ill    = (e.fmt == 3'd7);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one clock edge, updating the FIFO model with the transfers that
  // the pre-edge inputs and model occupancy imply.
  task automatic tick();
    bit   inF, outF, fl;
    exp_t e;
    inF  = inValid && (q.size() < 2);
    outF = (q.size() > 0) && outReady;
    fl   = flush;
    e    = refDecode(inInst, inPc);
    @(posedge CLK);
    if (fl) q.delete();
    else begin
      if (outF) q.delete(0);
      if (inF) q.push_back(e);
    end
    #1;
  endtask

  task automatic checkModel(input string tag);
    chk({tag, ".valid32"}, 64'(outValid32), 64'(q.size() > 0));
    chk({tag, ".ready32"}, 64'(inReady32), 64'(q.size() < 2));
    chk({tag, ".valid64"}, 64'(outValid64), 64'(q.size() > 0));
    chk({tag, ".ready64"}, 64'(inReady64), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, ".imm32"}, 64'(outImm32), 64'(q[0].imm[31:0]));
      chk({tag, ".fmt32"}, 64'(outFmt32), 64'(q[0].fmt));
      chk({tag, ".tgt32"}, 64'(outTarget32), 64'(q[0].target[31:0]));
      chk({tag, ".pc32"}, 64'(outPc32), 64'(q[0].pc[31:0]));
      chk({tag, ".ill32"}, 64'(outIll32), 64'(q[0].ill));
      chk({tag, ".imm64"}, outImm64, q[0].imm);
      chk({tag, ".fmt64"}, 64'(outFmt64), 64'(q[0].fmt));
      chk({tag, ".tgt64"}, outTarget64, q[0].target);
      chk({tag, ".pc64"}, outPc64, q[0].pc);
      chk({tag, ".ill64"}, 64'(outIll64), 64'(q[0].ill));
    end
  endtask

  task automatic checkResetValues(input string tag);
    chk({tag, ".valid"}, 64'({outValid32, outValid64}), 64'd0);
    chk({tag, ".ready"}, 64'({inReady32, inReady64}), 64'd3);
    chk({tag, ".imm"}, 64'(outImm32) | outImm64, 64'd0);
    chk({tag, ".fmt"}, 64'({outFmt32, outFmt64}), 64'd0);
    chk({tag, ".tgt"}, 64'(outTarget32) | outTarget64, 64'd0);
    chk({tag, ".pc"}, 64'(outPc32) | outPc64, 64'd0);
    chk({tag, ".ill"}, 64'({outIll32, outIll64}), 64'd0);
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc);
    inInst  = inst;
    inPc    = pc;
    inValid = 1'b1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'hFFF00093, 64'h100, 3'd1, 64'hFFFFFFFFFFFFFFFF, 64'hFF};
    vecs[1] = '{32'h800000B7, 64'h0,   3'd4, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000};
    vecs[2] = '{32'hFE000EE3, 64'h0,   3'd3, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
`ifdef IMMGEN_ZIMM_EN
    vecs[3] = '{32'h3401D073, 64'h1000, 3'd6, 64'h3, 64'h1003};
`else
    vecs[3] = '{32'h3401D073, 64'h1000, 3'd1, 64'h340, 64'h1340};
`endif
    vecs[4] = '{32'h0000007F, 64'h700, 3'd7, 64'h0, 64'h700};
    vecs[5] = '{32'h002081B3, 64'h600, 3'd0, 64'h0, 64'h600};
    vecs[6] = '{32'hFE112E23, 64'h200, 3'd2, 64'hFFFFFFFFFFFFFFFC, 64'h1FC};
    vecs[7] = '{32'h0080006F, 64'h40,  3'd5, 64'h8, 64'h48};
    vecs[8] = '{32'h00001097, 64'h80,  3'd4, 64'h1000, 64'h1080};
    vecs[9] = '{32'hFFC08067, 64'h500, 3'd1, 64'hFFFFFFFFFFFFFFFC, 64'h4FC};

    // Reset state
    #12;
    checkResetValues("reset");
    RST = 1'b0;
    @(posedge CLK); #1;
    checkResetValues("postReset");

    // Table-driven single-entry decodes
    outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].inst, vecs[i].pc);
      tick();
      inValid = 1'b0;
      chk($sformatf("vec%0d.valid", i), 64'({outValid32, outValid64}), 64'd3);
      chk($sformatf("vec%0d.fmt", i), 64'(outFmt64), 64'(vecs[i].fmt));
      chk($sformatf("vec%0d.imm64", i), outImm64, vecs[i].imm);
      chk($sformatf("vec%0d.tgt64", i), outTarget64, vecs[i].target);
      chk($sformatf("vec%0d.imm32", i), 64'(outImm32), 64'(vecs[i].imm[31:0]));
      chk($sformatf("vec%0d.tgt32", i), 64'(outTarget32), 64'(vecs[i].target[31:0]));
      chk($sformatf("vec%0d.ill", i), 64'({outIll32, outIll64}), (vecs[i].fmt == 3'd7) ? 64'd3 : 64'd0);
      checkModel($sformatf("vec%0d", i));
      tick();
      checkModel($sformatf("vec%0d.drain", i));
    end

    // Backpressure: three back-to-back offers, only two accepted
    outReady = 1'b0;
    send(32'h00100093, 64'h300);
    tick();
    chk("bp.ready1", 64'(inReady32), 64'd1);
    send(32'h00200093, 64'h304);
    tick();
    chk("bp.ready2", 64'({inReady32, inReady64}), 64'd0);
    send(32'h00300093, 64'h308);
    tick();
    chk("bp.ready3", 64'({inReady32, inReady64}), 64'd0);
    chk("bp.holdPc", outPc64, 64'h300);
    chk("bp.holdImm", 64'(outImm32), 64'd1);
    checkModel("bp.full");
    inValid  = 1'b0;
    outReady = 1'b1;
    tick();
    chk("bp.order2", outPc64, 64'h304);
    chk("bp.readyBack", 64'({inReady32, inReady64}), 64'd3);
    checkModel("bp.drain1");
    tick();
    chk("bp.noThird", 64'({outValid32, outValid64}), 64'd0);
    checkModel("bp.drain2");

    // Flush with both entries full and a same-edge input offer
    outReady = 1'b0;
    send(32'h00400093, 64'h400);
    tick();
    send(32'h00500093, 64'h404);
    tick();
    send(32'h00600093, 64'h408);
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    inValid = 1'b0;
    chk("flush.valid", 64'({outValid32, outValid64}), 64'd0);
    chk("flush.ready", 64'({inReady32, inReady64}), 64'd3);
    outReady = 1'b1;
    tick();
    chk("flush.gone", 64'({outValid32, outValid64}), 64'd0);
    checkModel("flush.after");

    // Illegal entry, then asynchronous reset between edges
    outReady = 1'b0;
    send(32'h0000007F, 64'h3C0);
    tick();
    inValid = 1'b0;
    chk("ill.fmt", 64'({outFmt32, outFmt64}), 64'h3F);
    chk("ill.flag", 64'({outIll32, outIll64}), 64'd3);
    chk("ill.imm", 64'(outImm32) | outImm64, 64'd0);
    chk("ill.pc", outPc64, 64'h3C0);
    #2;
    RST = 1'b1;
    #1;
    checkResetValues("asyncRst");
    q.delete();
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    checkModel("postAsyncRst");

    // Randomised traffic against the FIFO model
    begin
      logic [6:0]  ops[11];
      logic [31:0] r;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h23, 7'h63, 7'h33, 7'h00};
      for (int c = 0; c < 600; c++) begin
        r = $urandom();
        if ($urandom_range(10, 0) == 10) inInst = r;
        else inInst = {r[31:7], ops[$urandom_range(10, 0)]};
        inPc     = {$urandom(), $urandom()};
        inValid  = ($urandom_range(3, 0) != 0);
        outReady = ($urandom_range(2, 0) != 0);
        flush    = ($urandom_range(40, 0) == 0);
        tick();
        checkModel($sformatf("rnd%0d", c));
      end
      flush   = 1'b0;
      inValid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
